// File: rtl/updown_counter_multi.sv
// Up/down counter with run-time bounds, step and bounce/wrap/saturate modes.
// Optional prescaler enabled by defining UPDOWN_CNT_PRESCALE_EN.
module updown_counter_multi #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef UPDOWN_CNT_PRESCALE_EN
   ,
   parameter int               PRESCALE  = 4
`endif
) (
   input  logic             clock,
   input  logic             areset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             load_dir,
   output logic [WIDTH-1:0] data,
   output logic             dir,
   output logic             turn,
   output logic             at_hi,
   output logic             at_lo,
   output logic             cfg_err
);

   typedef enum logic [1:0] {
      MODE_BOUNCE     = 2'd0,
      MODE_WRAP       = 2'd1,
      MODE_SAT        = 2'd2,
      MODE_BOUNCE_ALT = 2'd3
   } mode_e;

   mode_e            mode_q;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   dn_dif;
   logic             over_hi;
   logic             under_lo;
   logic             below;
   logic             above;
   logic             tick;
   logic [WIDTH-1:0] data_nxt;
   logic             dir_nxt;
   logic             turn_nxt;

   assign mode_q  = mode_e'(mode);
   assign cfg_err = (lo > hi);
   assign at_hi   = (data == hi);
   assign at_lo   = (data == lo);
   assign below   = (data < lo);
   assign above   = (data > hi);

   // One extra bit keeps carry/borrow visible so no mode can wrap modulo 2^WIDTH.
   assign up_sum   = {1'b0, data} + {1'b0, step};
   assign dn_dif   = {1'b0, data} - {1'b0, step};
   assign over_hi  = (up_sum > {1'b0, hi});
   assign under_lo = dn_dif[WIDTH] | (dn_dif[WIDTH-1:0] < lo);

`ifdef UPDOWN_CNT_PRESCALE_EN
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0] ps_cnt;

   assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

   always_ff @(posedge clock or posedge areset) begin
      if (areset)
         ps_cnt <= '0;
      else if (load)
         ps_cnt <= '0;
      else if (en)
         ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
   end
`else
   assign tick = 1'b1;
`endif

   always_comb begin
      data_nxt = data;
      dir_nxt  = dir;
      turn_nxt = 1'b0;
      if (load) begin
         data_nxt = load_val;
         dir_nxt  = load_dir;
      end else if (cfg_err || !en || !tick) begin
         data_nxt = data;
      end else if (below) begin
         // Out-of-range value is pulled onto the nearest bound; stepping resumes next cycle.
         data_nxt = lo;
      end else if (above) begin
         data_nxt = hi;
      end else begin
         unique case (mode_q)
            MODE_WRAP: begin
               if (dir) begin
                  if (at_hi || over_hi) begin
                     data_nxt = lo;
                     turn_nxt = 1'b1;
                  end else begin
                     data_nxt = up_sum[WIDTH-1:0];
                  end
               end else begin
                  if (at_lo || under_lo) begin
                     data_nxt = hi;
                     turn_nxt = 1'b1;
                  end else begin
                     data_nxt = dn_dif[WIDTH-1:0];
                  end
               end
            end
            MODE_SAT: begin
               if (dir) begin
                  if (!at_hi)
                     data_nxt = over_hi ? hi : up_sum[WIDTH-1:0];
               end else begin
                  if (!at_lo)
                     data_nxt = under_lo ? lo : dn_dif[WIDTH-1:0];
               end
            end
            default: begin
               // Bounce: reaching a bound costs one dwell cycle, during which dir flips.
               if (dir) begin
                  if (at_hi) begin
                     dir_nxt  = 1'b0;
                     turn_nxt = 1'b1;
                  end else begin
                     data_nxt = over_hi ? hi : up_sum[WIDTH-1:0];
                  end
               end else begin
                  if (at_lo) begin
                     dir_nxt  = 1'b1;
                     turn_nxt = 1'b1;
                  end else begin
                     data_nxt = under_lo ? lo : dn_dif[WIDTH-1:0];
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         data <= RESET_VAL;
         dir  <= 1'b1;
         turn <= 1'b0;
      end else begin
         data <= data_nxt;
         dir  <= dir_nxt;
         turn <= turn_nxt;
      end
   end

endmodule

// File: tb/tb_updown_counter_multi.sv
// Bench for updown_counter_multi: vector table, corner sequences and random
// stimulus against an integer-arithmetic reference model.
module tb_updown_counter_multi;

   logic       clock = 1'b0;
   logic       areset;
   logic       en;
   logic [1:0] mode;
   logic [7:0] lo, hi, step, load_val;
   logic       load, load_dir;
   logic [7:0] data;
   logic       dir, turn, at_hi, at_lo, cfg_err;

   int checks = 0;
   int errors = 0;

   // reference model state and pending next state
   int md, mdir, mt;
   int nd, ndir, nt;

   typedef struct {
      bit       en;
      bit [1:0] mode;
      bit [7:0] lo, hi, step;
      bit       load;
      bit [7:0] lval;
      bit       ldir;
      int       e_data;
      bit       e_dir;
      bit       e_turn;
   } vec_t;

   vec_t tbl[$];

   updown_counter_multi #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
      .clock(clock), .areset(areset), .en(en), .mode(mode), .lo(lo), .hi(hi),
      .step(step), .load(load), .load_val(load_val), .load_dir(load_dir),
      .data(data), .dir(dir), .turn(turn), .at_hi(at_hi), .at_lo(at_lo),
      .cfg_err(cfg_err)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(bit e, bit [1:0] m, bit [7:0] l, bit [7:0] h, bit [7:0] s,
                               bit ld, bit [7:0] lv, bit lr, int xd, bit xr, bit xt);
      vec_t v;
      v.en = e; v.mode = m; v.lo = l; v.hi = h; v.step = s;
      v.load = ld; v.lval = lv; v.ldir = lr;
      v.e_data = xd; v.e_dir = xr; v.e_turn = xt;
      return v;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Next state from plain integer arithmetic on the behavioural rules.
   task automatic model_next();
      int l, h, s, tgt, bound;
      bit past;
      l = int'(lo); h = int'(hi); s = int'(step);
      nd = md; ndir = mdir; nt = 0;
      if (load) begin
         nd = int'(load_val); ndir = int'(load_dir);
      end else if (l > h || !en) begin
         nd = md;
      end else if (md < l) begin
         nd = l;
      end else if (md > h) begin
         nd = h;
      end else begin
         tgt   = (mdir != 0) ? md + s : md - s;
         bound = (mdir != 0) ? h : l;
         past  = (mdir != 0) ? (tgt > h) : (tgt < l);
         if (mode == 2'd1) begin
            if (md == bound || past) begin
               nd = (mdir != 0) ? l : h;
               nt = 1;
            end else nd = tgt;
         end else if (md == bound) begin
            if (mode != 2'd2) begin
               ndir = 1 - mdir;
               nt = 1;
            end
         end else begin
            nd = past ? bound : tgt;
         end
      end
   endtask

   task automatic cyc();
      model_next();
      @(posedge clock);
      #1;
      md = nd; mdir = ndir; mt = nt;
      chk("data", int'(data), md);
      chk("dir", int'(dir), mdir);
      chk("turn", int'(turn), mt);
      chk("at_hi", int'(at_hi), int'(md == int'(hi)));
      chk("at_lo", int'(at_lo), int'(md == int'(lo)));
      chk("cfg_err", int'(cfg_err), int'(lo > hi));
   endtask

   initial begin
      areset = 1'b1; en = 1'b1; mode = 2'd0; lo = 8'd0; hi = 8'd32; step = 8'd1;
      load = 1'b0; load_val = 8'd0; load_dir = 1'b1;
      md = 0; mdir = 1; mt = 0;
      #1;
      chk("rst_data", int'(data), 0);
      chk("rst_dir", int'(dir), 1);
      chk("rst_turn", int'(turn), 0);
      @(negedge clock);
      areset = 1'b0;

      // bounce 0..32, one full 66-cycle period and one more step
      for (int i = 1; i <= 67; i++) begin
         cyc();
         if (i == 32) begin chk("bnc_top", int'(data), 32); chk("bnc_top_turn", int'(turn), 0); end
         if (i == 33) begin chk("bnc_dwell", int'(data), 32); chk("bnc_dwell_dir", int'(dir), 0);
                            chk("bnc_dwell_turn", int'(turn), 1); end
         if (i == 66) begin chk("bnc_bot", int'(data), 0); chk("bnc_bot_turn", int'(turn), 1); end
         if (i == 67) chk("bnc_rise", int'(data), 1);
      end

      // bounds shrink below current value, then inverted bounds, then load under cfg_err
      lo = 8'd0; hi = 8'd100; load = 1'b1; load_val = 8'd50; load_dir = 1'b1;
      cyc();
      load = 1'b0; hi = 8'd40;
      cyc();
      chk("clamp_hi", int'(data), 40); chk("clamp_turn", int'(turn), 0);
      lo = 8'd60;
      #1 chk("cfg_err_set", int'(cfg_err), 1);
      cyc();
      chk("cfg_hold", int'(data), 40);
      load = 1'b1; load_val = 8'd77; load_dir = 1'b0;
      cyc();
      chk("cfg_load", int'(data), 77);
      load = 1'b0;

      // async reset mid-cycle during a down count
      lo = 8'd0; hi = 8'd32; load = 1'b1; load_val = 8'd18; load_dir = 1'b0;
      cyc();
      load = 1'b0;
      cyc();
      chk("pre_rst", int'(data), 17);
      #2 areset = 1'b1;
      #1;
      chk("async_data", int'(data), 0);
      chk("async_dir", int'(dir), 1);
      @(negedge clock);
      areset = 1'b0; md = 0; mdir = 1; mt = 0;
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("en0_data", int'(data), 0);
         chk("en0_turn", int'(turn), 0);
      end

      // vector table: bounce overshoot, wrap near 8-bit top, saturate
      tbl.push_back(mk(1, 0, 3, 20, 6, 1, 3, 1,  3, 1, 0));
      tbl.push_back(mk(1, 0, 3, 20, 6, 0, 0, 0,  9, 1, 0));
      tbl.push_back(mk(1, 0, 3, 20, 6, 0, 0, 0, 15, 1, 0));
      tbl.push_back(mk(1, 0, 3, 20, 6, 0, 0, 0, 20, 1, 0));
      tbl.push_back(mk(1, 0, 3, 20, 6, 0, 0, 0, 20, 0, 1));
      tbl.push_back(mk(1, 0, 3, 20, 6, 0, 0, 0, 14, 0, 0));
      tbl.push_back(mk(1, 0, 3, 20, 6, 0, 0, 0,  8, 0, 0));
      tbl.push_back(mk(1, 0, 3, 20, 6, 0, 0, 0,  3, 0, 0));
      tbl.push_back(mk(1, 0, 3, 20, 6, 0, 0, 0,  3, 1, 1));
      tbl.push_back(mk(1, 0, 3, 20, 6, 0, 0, 0,  9, 1, 0));
      tbl.push_back(mk(1, 1, 250, 255, 4, 1, 250, 1, 250, 1, 0));
      tbl.push_back(mk(1, 1, 250, 255, 4, 0, 0, 0, 254, 1, 0));
      tbl.push_back(mk(1, 1, 250, 255, 4, 0, 0, 0, 250, 1, 1));
      tbl.push_back(mk(1, 1, 250, 255, 4, 0, 0, 0, 254, 1, 0));
      tbl.push_back(mk(1, 2, 0, 10, 3, 1, 8, 1,  8, 1, 0));
      tbl.push_back(mk(1, 2, 0, 10, 3, 0, 0, 0, 10, 1, 0));
      tbl.push_back(mk(1, 2, 0, 10, 3, 0, 0, 0, 10, 1, 0));
      tbl.push_back(mk(1, 2, 0, 10, 3, 0, 0, 0, 10, 1, 0));
      tbl.push_back(mk(1, 2, 0, 10, 3, 1, 10, 0, 10, 0, 0));
      tbl.push_back(mk(1, 2, 0, 10, 3, 0, 0, 0,  7, 0, 0));
      tbl.push_back(mk(1, 2, 0, 10, 3, 0, 0, 0,  4, 0, 0));
      tbl.push_back(mk(1, 2, 0, 10, 3, 0, 0, 0,  1, 0, 0));
      tbl.push_back(mk(1, 2, 0, 10, 3, 0, 0, 0,  0, 0, 0));
      tbl.push_back(mk(1, 2, 0, 10, 3, 0, 0, 0,  0, 0, 0));
      tbl.push_back(mk(1, 0, 9, 9, 0, 1, 9, 1,  9, 1, 0));
      tbl.push_back(mk(1, 0, 9, 9, 0, 0, 0, 0,  9, 0, 1));
      tbl.push_back(mk(1, 0, 9, 9, 0, 0, 0, 0,  9, 1, 1));
      tbl.push_back(mk(1, 1, 9, 9, 2, 0, 0, 0,  9, 1, 1));
      foreach (tbl[i]) begin
         en = tbl[i].en; mode = tbl[i].mode; lo = tbl[i].lo; hi = tbl[i].hi;
         step = tbl[i].step; load = tbl[i].load; load_val = tbl[i].lval;
         load_dir = tbl[i].ldir;
         cyc();
         chk($sformatf("vec%0d_data", i), int'(data), tbl[i].e_data);
         chk($sformatf("vec%0d_dir", i), int'(dir), int'(tbl[i].e_dir));
         chk($sformatf("vec%0d_turn", i), int'(turn), int'(tbl[i].e_turn));
      end

      // random bursts with configuration held per burst
      for (int b = 0; b < 100; b++) begin
         mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) begin
            lo = 8'($urandom_range(235, 255)); hi = 8'($urandom_range(235, 255));
            step = 8'($urandom_range(0, 255));
         end else begin
            lo = 8'($urandom_range(0, 20)); hi = 8'($urandom_range(0, 24));
            step = 8'($urandom_range(0, 6));
         end
         for (int c = 0; c < 8; c++) begin
            en = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 11) == 0);
            load_val = 8'($urandom_range(0, 255));
            load_dir = 1'($urandom_range(0, 1));
            cyc();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_counter_multi.md
Name: updown_counter_multi

Overview:
- Parametrised successor to the fixed 8-bit, 0..32 bounce counter.
- Adds a generic width, run-time low/high bounds and step size, three count modes, enable, synchronous load, and turnaround/terminal status outputs.
- Used as a pattern/address generator and as the standard up/down stimulus DUT for the UVM practice benches.

Parameters:
- WIDTH, 8, bit width of data, bounds, step and load value.
- RESET_VAL, 0, value of data after reset.

Ports:
- clock  in  1  rising-edge clock.
- areset  in  1  asynchronous reset, active-high.
- en  in  1  count enable; when 0, data and dir hold.
- mode  in  2  0=bounce, 1=wrap, 2=saturate, 3=treated as bounce.
- lo  in  WIDTH  lower bound, inclusive.
- hi  in  WIDTH  upper bound, inclusive.
- step  in  WIDTH  increment magnitude; 0 means data holds.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded into data.
- load_dir  in  1  direction loaded with load (1=up).
- data  out  WIDTH  counter value, registered.
- dir  out  1  current direction (1=up), registered.
- turn  out  1  one-cycle pulse, registered; asserted the cycle after a direction flip or wrap.
- at_hi  out  1  combinational: data==hi.
- at_lo  out  1  combinational: data==lo.
- cfg_err  out  1  combinational: lo>hi.

Behaviour:
- Reset (async, areset=1): data=RESET_VAL, dir=1, turn=0. Counting resumes on the first rising edge after areset deasserts.
- Per-edge priority: reset > load > cfg_err hold > en=0 hold > out-of-range correction > mode step.
- load=1: data<=load_val, dir<=load_dir, turn<=0. Applies regardless of en and cfg_err. No clamping at load time.
- cfg_err=1 with no load: data and dir hold, turn=0.
- Out-of-range correction (en=1 and data<lo or data>hi): data<=lo if below, hi if above. dir unchanged, no turn pulse. Takes one cycle; mode stepping resumes the next cycle.
- Step arithmetic is WIDTH+1 bits. Up candidate = data+step; down candidate = data-step with a borrow check. No silent modular overflow in any mode.
- Bounce mode:
  - Up: if data==hi, then dir<=0, data holds, turn<=1 (one dwell cycle at the bound). Else if data+step>hi, data<=hi. Else data<=data+step.
  - Down: mirror image using lo and dir<=1.
- Wrap mode:
  - Up: if data==hi or data+step>hi, data<=lo and turn<=1, with no dwell. Else data<=data+step. dir is never changed by counting.
  - Down: mirror image; data<=hi on passing lo.
- Saturate mode: as bounce, except that at the bound data holds indefinitely, dir does not flip and turn stays 0. Leaves the bound only via load, a dir change through load, or a mode change.
- Mode change mid-count takes effect at the next edge; data and dir are not reset.
- lo==hi: bounce toggles dir every enabled cycle with turn=1 each cycle; wrap keeps data=lo with turn=1 each cycle; saturate holds.
- step=0 with en=1: data holds. A turnaround or wrap still fires if data is already at the bound in the current direction.
- turn is 0 in every cycle not listed above, including en=0 cycles.

Optional Feature:
- Macro UPDOWN_CNT_PRESCALE_EN.
- Defined: adds parameter PRESCALE (default 4) and an internal prescale counter of clog2(PRESCALE) bits.
  - A count or correction step occurs only on enabled cycles where the prescaler is at terminal value PRESCALE-1. The prescaler advances only when en=1.
  - load clears the prescaler. Reset clears it to 0.
  - turn still pulses for exactly one clock.
- Undefined: no prescaler logic; every enabled cycle steps.

Test Plan:
- Bounce, lo=0, hi=32, step=1, en=1 from reset: data runs 0..32, holds 32 for one cycle with turn=1 the following cycle and dir=0, runs down to 0, dwells one cycle, then rises. Full period 66 cycles.
- Bounce overshoot, lo=3, hi=20, step=6, load 3 up: data goes 3,9,15,20,20(turn),14,8,3,3(turn),9.
- Wrap, WIDTH=8, lo=250, hi=255, step=4, load 250 up: data goes 250,254,250(turn) with no dwell. Confirm no 8-bit modular overflow to 2.
- Saturate, lo=0, hi=10, step=3, load 8 up: data goes 8,10,10,10… with turn=0 and dir=1. Then load_dir=0 via load 10 brings data down 10,7,4,1,0,0.
- Bounds change mid-count: counting at data=50 with hi set to 40 → next edge data=40, no turn. Setting lo=60 and hi=40 → cfg_err=1 and data holds. Loading while cfg_err=1 still takes load_val.
- areset asserted mid-cycle during a down-count at data=17: data=RESET_VAL and dir=1 immediately, without waiting for a clock edge. en=0 for 5 cycles after release: data holds and turn=0.
